// File: rtl/ws_mac_pe_db.sv
// Double-buffered weight-stationary MAC PE: a shadow weight loads while the active weight computes.
// Optional clamp-on-overflow behaviour is enabled by defining MAC_PE_SATURATE_EN.
module ws_mac_pe_db #(
    parameter int bit_width = 8,
    parameter int acc_width = 32,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [bit_width-1:0] data_in,
    input  logic                 data_valid_in,
    input  logic [acc_width-1:0] acc_in,
    input  logic [bit_width-1:0] wt_path_in,
    input  logic                 wt_valid_in,
    input  logic                 wt_swap_in,
    output logic [bit_width-1:0] data_out,
    output logic                 data_valid_out,
    output logic [acc_width-1:0] acc_out,
    output logic [bit_width-1:0] wt_path_out,
    output logic                 wt_valid_out,
    output logic                 wt_swap_out,
    output logic                 shadow_full,
    output logic [1:0]           status
);

    localparam int prod_width = 2 * bit_width;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } shadow_state_t;

    shadow_state_t               state;
    logic [bit_width-1:0]        w_active;
    logic [bit_width-1:0]        w_shadow;
    logic                        swap_err;
    logic                        acc_ovf;

    logic signed [prod_width-1:0] data_ext;
    logic signed [prod_width-1:0] wt_ext;
    logic signed [prod_width-1:0] prod;
    logic [acc_width-1:0]         prod_ext;
    logic [acc_width-1:0]         sum;
    logic                         carry;
    logic                         ovf;
    logic [acc_width-1:0]         acc_next;

    // Operands are widened before multiplying so the low product bits are exact in either mode.
    generate
        if (SIGNED != 0) begin : g_signed
            assign data_ext = {{bit_width{data_in[bit_width-1]}}, data_in};
            assign wt_ext   = {{bit_width{w_active[bit_width-1]}}, w_active};
            assign prod     = data_ext * wt_ext;
            assign prod_ext = acc_width'(prod);
            assign ovf      = (acc_in[acc_width-1] == prod_ext[acc_width-1]) &&
                              (sum[acc_width-1] != acc_in[acc_width-1]);
        end else begin : g_unsigned
            assign data_ext = {{bit_width{1'b0}}, data_in};
            assign wt_ext   = {{bit_width{1'b0}}, w_active};
            assign prod     = data_ext * wt_ext;
            assign prod_ext = acc_width'($unsigned(prod));
            assign ovf      = carry;
        end
    endgenerate

    assign {carry, sum} = {1'b0, acc_in} + {1'b0, prod_ext};

`ifdef MAC_PE_SATURATE_EN
    // Signed overflow can only happen when both addends share a sign, so acc_in's sign picks the rail.
    always_comb begin
        // NOTE: default assignment first so no path leaves acc_next unassigned (no latch).
        acc_next = sum;
        if (ovf) begin
            if (SIGNED != 0)
                acc_next = acc_in[acc_width-1] ? {1'b1, {(acc_width-1){1'b0}}}
                                               : {1'b0, {(acc_width-1){1'b1}}};
            else
                acc_next = '1;
        end
    end
`else
    assign acc_next = sum;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
            acc_out        <= '0;
            wt_path_out    <= '0;
            wt_valid_out   <= 1'b0;
            wt_swap_out    <= 1'b0;
            acc_ovf        <= 1'b0;
        end else begin
            data_out       <= data_in;
            data_valid_out <= data_valid_in;
            wt_path_out    <= wt_path_in;
            wt_valid_out   <= wt_valid_in;
            wt_swap_out    <= wt_swap_in;
            if (data_valid_in) begin
                acc_out <= acc_next;
                if (ovf)
                    acc_ovf <= 1'b1;
            end
        end
    end

    // Shadow FSM; the product above reads w_active before this edge updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            w_active    <= '0;
            w_shadow    <= '0;
            shadow_full <= 1'b0;
            swap_err    <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (wt_swap_in)
                        swap_err <= 1'b1;
                    if (wt_valid_in) begin
                        w_shadow    <= wt_path_in;
                        state       <= FULL;
                        shadow_full <= 1'b1;
                    end
                end
                FULL: begin
                    if (wt_swap_in)
                        w_active <= w_shadow;
                    if (wt_valid_in) begin
                        w_shadow    <= wt_path_in;
                        state       <= FULL;
                        shadow_full <= 1'b1;
                    end else if (wt_swap_in) begin
                        state       <= EMPTY;
                        shadow_full <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    shadow_full <= 1'b0;
                end
            endcase
        end
    end

    assign status = {acc_ovf, swap_err};

endmodule

// File: tb/tb_ws_mac_pe_db.sv
// Scoreboard bench for ws_mac_pe_db: an unsigned and a signed instance share one stimulus stream
// and are compared every cycle against an integer-arithmetic reference model.
module tb_ws_mac_pe_db;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;
    localparam longint UMAX = 64'sd4294967295;

    typedef struct packed {
        logic [7:0]  d;
        logic        dv;
        logic [31:0] acc;
        logic [7:0]  wp;
        logic        wv;
        logic        sw;
        logic        sf;
        logic [1:0]  st;
    } obs_t;

    typedef struct packed {
        obs_t u;
        obs_t s;
    } obs_pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = '0;
    logic        data_valid_in = 1'b0;
    logic [31:0] acc_in = '0;
    logic [7:0]  wt_path_in = '0;
    logic        wt_valid_in = 1'b0;
    logic        wt_swap_in = 1'b0;

    logic [7:0]  u_data_out, s_data_out, u_wt_path_out, s_wt_path_out;
    logic        u_dv_out, s_dv_out, u_wv_out, s_wv_out, u_sw_out, s_sw_out, u_full, s_full;
    logic [31:0] u_acc_out, s_acc_out;
    logic [1:0]  u_status, s_status;

    int n_cmp = 0;
    int n_bad = 0;

    obs_pair_t sb_q[$];

    // Reference model state, index 0 = unsigned instance, 1 = signed instance.
    logic [7:0]  m_act[2];
    logic [7:0]  m_shd[2];
    logic        m_full[2];
    logic        m_err[2];
    logic        m_ovf[2];
    logic [31:0] m_acc[2];

    always #5 clk = ~clk;

    ws_mac_pe_db #(.bit_width(8), .acc_width(32), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_valid_in(data_valid_in), .acc_in(acc_in),
        .wt_path_in(wt_path_in), .wt_valid_in(wt_valid_in), .wt_swap_in(wt_swap_in),
        .data_out(u_data_out), .data_valid_out(u_dv_out), .acc_out(u_acc_out),
        .wt_path_out(u_wt_path_out), .wt_valid_out(u_wv_out), .wt_swap_out(u_sw_out),
        .shadow_full(u_full), .status(u_status)
    );

    ws_mac_pe_db #(.bit_width(8), .acc_width(32), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst),
        .data_in(data_in), .data_valid_in(data_valid_in), .acc_in(acc_in),
        .wt_path_in(wt_path_in), .wt_valid_in(wt_valid_in), .wt_swap_in(wt_swap_in),
        .data_out(s_data_out), .data_valid_out(s_dv_out), .acc_out(s_acc_out),
        .wt_path_out(s_wt_path_out), .wt_valid_out(s_wv_out), .wt_swap_out(s_sw_out),
        .shadow_full(s_full), .status(s_status)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic obs_t sample(input int m);
        obs_t o;
        if (m == 0)
            o = '{u_data_out, u_dv_out, u_acc_out, u_wt_path_out, u_wv_out, u_sw_out, u_full, u_status};
        else
            o = '{s_data_out, s_dv_out, s_acc_out, s_wt_path_out, s_wv_out, s_sw_out, s_full, s_status};
        return o;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_act[m] = '0; m_shd[m] = '0; m_full[m] = 1'b0;
            m_err[m] = 1'b0; m_ovf[m] = 1'b0; m_acc[m] = '0;
        end
    endtask

    // Computes what each instance must show after the coming edge and queues it.
    task automatic model_cycle();
        obs_pair_t pr;
        obs_t      e[2];
        for (int m = 0; m < 2; m++) begin
            if (data_valid_in) begin
                longint a, p, total;
                logic   ovf;
                if (m == 1) begin
                    a = longint'($signed(acc_in));
                    p = longint'($signed(data_in)) * longint'($signed(m_act[m]));
                    ovf = (total_gt(a + p, SMAX) || (a + p) < SMIN);
                end else begin
                    a = longint'(acc_in);
                    p = longint'(data_in) * longint'(m_act[m]);
                    ovf = total_gt(a + p, UMAX);
                end
                total = a + p;
                m_acc[m] = 32'(total);
`ifdef MAC_PE_SATURATE_EN
                if (ovf)
                    m_acc[m] = (m == 1) ? ((total > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : 32'hFFFF_FFFF;
`endif
                if (ovf)
                    m_ovf[m] = 1'b1;
            end
            if (wt_swap_in) begin
                if (m_full[m])
                    m_act[m] = m_shd[m];
                else
                    m_err[m] = 1'b1;
                m_full[m] = 1'b0;
            end
            if (wt_valid_in) begin
                m_shd[m]  = wt_path_in;
                m_full[m] = 1'b1;
            end
            e[m] = '{data_in, data_valid_in, m_acc[m], wt_path_in, wt_valid_in, wt_swap_in,
                     m_full[m], {m_ovf[m], m_err[m]}};
        end
        pr.u = e[0];
        pr.s = e[1];
        sb_q.push_back(pr);
    endtask

    function automatic logic total_gt(input longint v, input longint lim);
        return v > lim;
    endfunction

    task automatic step(input logic [7:0] d, input logic v, input logic [31:0] a,
                        input logic [7:0] w, input logic wv, input logic s);
        @(negedge clk);
        data_in = d; data_valid_in = v; acc_in = a;
        wt_path_in = w; wt_valid_in = wv; wt_swap_in = s;
        model_cycle();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        data_in = '0; data_valid_in = 1'b0; acc_in = '0;
        wt_path_in = '0; wt_valid_in = 1'b0; wt_swap_in = 1'b0;
    endtask

    // Monitor: every post-reset edge the DUTs present a full output set.
    initial begin
        obs_pair_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                ex = sb_q.pop_front();
                check("sb_unsigned", 64'(sample(0)), 64'(ex.u));
                check("sb_signed", 64'(sample(1)), 64'(ex.s));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        idle_inputs();
        #1;
        check("reset_u_outputs", 64'(sample(0)), 64'd0);
        check("reset_s_outputs", 64'(sample(1)), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Load 3, promote, compute 10 + 5*3.
        step(8'd0, 1'b0, 32'd0, 8'd3, 1'b1, 1'b0); settle();
        check("t1_full_after_load", 64'(u_full), 64'd1);
        step(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1); settle();
        check("t1_empty_after_swap", 64'(u_full), 64'd0);
        step(8'd5, 1'b1, 32'd10, 8'd0, 1'b0, 1'b0); settle();
        check("t1_acc_u", 64'(u_acc_out), 64'd25);
        check("t1_acc_s", 64'(s_acc_out), 64'd25);

        // Overlapped load: swap cycle still uses 3, next cycle uses 7.
        step(8'd2, 1'b1, 32'd0, 8'd7, 1'b1, 1'b0); settle();
        check("t2_pre_swap", 64'(u_acc_out), 64'd6);
        step(8'd2, 1'b1, 32'd0, 8'd0, 1'b0, 1'b1); settle();
        check("t2_swap_cycle", 64'(u_acc_out), 64'd6);
        step(8'd2, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0); settle();
        check("t2_post_swap", 64'(u_acc_out), 64'd14);
        check("t2_no_bubble", 64'(u_dv_out), 64'd1);

        // Swap while EMPTY sets swap_err, active stays 7.
        step(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1); settle();
        check("t3_swap_err", 64'(u_status), 64'd1);
        step(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0); settle();
        check("t3_active_kept", 64'(u_acc_out), 64'd7);
        check("t3_sticky", 64'(u_status), 64'd1);

        // Signed weight -2.
        step(8'd0, 1'b0, 32'd0, 8'hFE, 1'b1, 1'b0);
        step(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
        step(8'd100, 1'b1, 32'd50, 8'd0, 1'b0, 1'b0); settle();
        check("t4_signed_acc", 64'(s_acc_out), 64'hFFFF_FF6A);
        check("t4_unsigned_acc", 64'(u_acc_out), 64'h636A);

        // Unsigned overflow.
        step(8'd0, 1'b0, 32'd0, 8'd1, 1'b1, 1'b0);
        step(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
        step(8'h20, 1'b1, 32'hFFFF_FFF0, 8'd0, 1'b0, 1'b0); settle();
`ifdef MAC_PE_SATURATE_EN
        check("t5_ovf_acc", 64'(u_acc_out), 64'hFFFF_FFFF);
`else
        check("t5_ovf_acc", 64'(u_acc_out), 64'h10);
`endif
        check("t5_ovf_status", 64'(u_status), 64'd3);
        check("t5_signed_no_ovf", 64'(s_status), 64'd1);

        // Simultaneous swap and load while FULL.
        step(8'd0, 1'b0, 32'd0, 8'd4, 1'b1, 1'b0);
        step(8'd0, 1'b0, 32'd0, 8'd9, 1'b1, 1'b1); settle();
        check("t6_full_kept", 64'(u_full), 64'd1);
        step(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0); settle();
        check("t6_active_old_shadow", 64'(u_acc_out), 64'd4);
        step(8'd0, 1'b0, 32'd0, 8'd0, 1'b0, 1'b1);
        step(8'd1, 1'b1, 32'd0, 8'd0, 1'b0, 1'b0); settle();
        check("t6_shadow_new", 64'(u_acc_out), 64'd9);

        // Random traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0)
                a = ($urandom_range(0, 1) ? 32'hFFFF_FF00 : 32'h7FFF_FF00) | 32'($urandom_range(0, 255));
            step(8'($urandom), 1'($urandom_range(0, 1)), a, 8'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            if (i == 200) begin
                #2;
                rst = 1'b1;
                idle_inputs();
                #1;
                check("midrst_u_outputs", 64'(sample(0)), 64'd0);
                check("midrst_s_outputs", 64'(sample(1)), 64'd0);
                sb_q.delete();
                model_reset();
                repeat (2) @(negedge clk);
                rst = 1'b0;
                step(8'h11, 1'b1, 32'h100, 8'd0, 1'b0, 1'b0); settle();
                check("midrst_weight_zero", 64'(u_acc_out), 64'h100);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ws_mac_pe_db.md
Name: ws_mac_pe_db

Overview:
Parametrised, double-buffered weight-stationary MAC processing element for the systolic array.
- Weights stream down the column into a shadow register while the PE keeps computing with its active weight.
- A propagated swap pulse promotes shadow to active without stalling the activation stream.
- Adds valid qualification, a signed/unsigned mode and sticky overflow/protocol status.
- Instantiated per PE by the array wrapper; all outputs registered, one-cycle hop per PE.

Parameters:
- bit_width, 8, width of activations and weights.
- acc_width, 32, width of partial sums; must be >= 2*bit_width.
- SIGNED, 0, 1 = two's-complement operands and accumulation; 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- data_in  input  bit_width  activation from left neighbour.
- data_valid_in  input  1  qualifies data_in and acc_in.
- acc_in  input  acc_width  partial sum from upper neighbour.
- wt_path_in  input  bit_width  weight from upper neighbour.
- wt_valid_in  input  1  qualifies wt_path_in.
- wt_swap_in  input  1  single-cycle promote pulse.
- data_out  output  bit_width  registered data_in.
- data_valid_out  output  1  registered data_valid_in.
- acc_out  output  acc_width  registered acc_in + data_in*active weight.
- wt_path_out  output  bit_width  registered wt_path_in.
- wt_valid_out  output  1  registered wt_valid_in.
- wt_swap_out  output  1  registered wt_swap_in.
- shadow_full  output  1  shadow holds an unpromoted weight.
- status  output  2  bit0 sticky swap_err, bit1 sticky acc_ovf.

Behaviour:
- Async reset: all outputs 0; active weight, shadow weight, shadow_full and status cleared. Reset mid-stream discards in-flight data; first valid after release is computed with weight 0.
- Pass-through: data_out, data_valid_out, wt_path_out, wt_valid_out and wt_swap_out are one-cycle delayed copies, updated every cycle regardless of valid.
- Compute: when data_valid_in=1, acc_out <= acc_in + ext(data_in*w_active) next edge. Latency 1.
- Product width is 2*bit_width, sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to acc_width. Sum wraps modulo 2^acc_width.
- When data_valid_in=0, acc_out holds its previous value.
- Shadow FSM, states EMPTY/FULL (shadow_full = state==FULL):
  - EMPTY: wt_valid_in -> shadow <= wt_path_in, go FULL.
  - FULL: wt_valid_in -> shadow overwritten, stay FULL. Last write wins; this is legal and is how weights shift past.
  - FULL: wt_swap_in -> w_active <= shadow, go EMPTY.
  - FULL: wt_swap_in and wt_valid_in in the same cycle -> active takes the old shadow, shadow takes the new weight, stay FULL.
  - EMPTY: wt_swap_in -> active unchanged, status[0] set.
- Swap/compute ordering: a swap in cycle N affects only products with data_valid_in in cycle N+1 or later. A product in cycle N uses the pre-swap weight.
- Overflow detection:
  - SIGNED=1: operands of the sum share a sign and the result sign differs.
  - SIGNED=0: carry out of the top bit.
  - On a valid cycle either condition sets status[1].
- status bits are sticky; only rst clears them.

Optional Feature:
- Macro MAC_PE_SATURATE_EN.
- Defined: on overflow, acc_out clamps to the max/min representable value for the mode (unsigned: all ones; signed: 0x7FFF_FFFF / 0x8000_0000 at default width). status[1] is still set.
- Undefined: wrap-around as above; no saturation logic is synthesised.

Test Plan:
- Reset then load and compute: wt_path_in=3 with wt_valid_in, next cycle wt_swap_in, then data_in=5, acc_in=10, valid -> acc_out=25 one cycle later; shadow_full 1 then 0.
- Overlapped load: active=3; while streaming data_in=2 every cycle load shadow=7, swap in cycle N -> products in cycles <=N use 3 (acc_in=0 gives 6); from N+1 they use 7 (gives 14); no bubble in data_valid_out.
- Swap with shadow EMPTY -> active unchanged; status=01 and it stays set until rst.
- SIGNED=1: weight=-2 (0xFE), data_in=100, acc_in=50 -> acc_out=0xFFFFFF6A (-150).
- Overflow: SIGNED=0, acc_in=0xFFFFFFF0, weight=1, data_in=0x20 -> status[1]=1; acc_out=0x10 (macro undefined) or 0xFFFFFFFF (MAC_PE_SATURATE_EN defined).
- Simultaneous swap and load when FULL (shadow=4, new weight 9) -> active=4, shadow=9, shadow_full stays 1. Assert rst mid-stream -> all outputs 0 immediately, asynchronously.
